// File: rtl/watches_time_set.sv
// User time-entry stage: button conditioning, hour/minute setting FSM,
// apply strobe and blink phase for the display.
module watches_time_set #(
  parameter int unsigned CLK_FREQ    = 50,
  parameter int unsigned SIM         = 0,
  parameter int unsigned DEBOUNCE_MS = 20,
  parameter int unsigned TIMEOUT_S   = 10
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       mode_btn_i,
  input  logic       inc_btn_i,
  input  logic [4:0] cur_hour_i,
  input  logic [5:0] cur_min_i,
  output logic [4:0] user_hour_o,
  output logic [5:0] user_min_o,
  output logic       user_time_val_o,
  output logic [1:0] set_mode_o,
  output logic       blink_o
);

  localparam int unsigned TICK_N   = (SIM != 0) ? CLK_FREQ : CLK_FREQ * 1000;
  localparam int unsigned PW       = $clog2(TICK_N + 1);
  localparam int unsigned DW       = $clog2(DEBOUNCE_MS + 1);
  localparam int unsigned TO_MS    = TIMEOUT_S * 1000;
  localparam int unsigned TW       = $clog2(TO_MS + 1);
  localparam int unsigned BLINK_MS = 500;
  localparam int unsigned BW       = $clog2(BLINK_MS + 1);
  localparam int unsigned NBTN     = 2;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_SET_HOUR = 2'd1,
    S_SET_MIN  = 2'd2,
    S_APPLY    = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Millisecond tick prescaler
  // ---------------------------------------------------------------------------
  logic [PW-1:0] r_presc;
  logic          w_ms_tick;

  assign w_ms_tick = (r_presc == PW'(TICK_N - 1));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_presc <= '0;
    end else if (w_ms_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Button synchronizers, debouncers and press detectors (bit 0 mode, bit 1 inc)
  // ---------------------------------------------------------------------------
  logic [NBTN-1:0] w_btn;
  logic [NBTN-1:0] r_sync1;
  logic [NBTN-1:0] r_sync2;
  logic [NBTN-1:0] r_db;
  logic [NBTN-1:0] r_db_d;
  logic [NBTN-1:0] r_arm;
  logic [DW-1:0]   r_dcnt [NBTN];
  logic [NBTN-1:0] w_press;
  logic            w_mode_p;
  logic            w_inc_p;

  assign w_btn = {inc_btn_i, mode_btn_i};

  // A button held through reset must be seen released before it can press.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_db    <= '0;
      r_db_d  <= '0;
      r_arm   <= '0;
      for (int i = 0; i < int'(NBTN); i++) begin
        r_dcnt[i] <= '0;
      end
    end else begin
      r_sync1 <= w_btn;
      r_sync2 <= r_sync1;
      r_db_d  <= r_db;
      for (int i = 0; i < int'(NBTN); i++) begin
        if (r_sync2[i] == r_db[i]) begin
          r_dcnt[i] <= '0;
        end else if (w_ms_tick) begin
          if (r_dcnt[i] == DW'(DEBOUNCE_MS - 1)) begin
            r_db[i]   <= r_sync2[i];
            r_dcnt[i] <= '0;
          end else begin
            r_dcnt[i] <= r_dcnt[i] + DW'(1);
          end
        end
        if (w_ms_tick && !r_sync2[i] && !r_db[i]) begin
          r_arm[i] <= 1'b1;
        end
      end
    end
  end

  assign w_press  = r_db & ~r_db_d & r_arm;
  assign w_mode_p = w_press[0];
  assign w_inc_p  = w_press[1];

  // ---------------------------------------------------------------------------
  // Setting FSM: state register
  // ---------------------------------------------------------------------------
  state_t r_state;
  state_t w_state_nxt;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Setting FSM: next state, edit values, timeout and blink
  // ---------------------------------------------------------------------------
  logic [4:0]    r_hour;
  logic [5:0]    r_min;
  logic          r_val;
  logic [1:0]    r_set_mode;
  logic          r_blink;
  logic [TW-1:0] r_to_cnt;
  logic [BW-1:0] r_bl_cnt;

  logic [4:0]    w_hour_nxt;
  logic [5:0]    w_min_nxt;
  logic          w_val_nxt;
  logic [1:0]    w_set_mode_nxt;
  logic          w_blink_nxt;
  logic [TW-1:0] w_to_nxt;
  logic [BW-1:0] w_bl_nxt;
  logic          w_to_hit;
  logic          w_editing;

  always_comb begin
    w_state_nxt    = r_state;
    w_hour_nxt     = r_hour;
    w_min_nxt      = r_min;
    w_to_nxt       = r_to_cnt;
    w_bl_nxt       = r_bl_cnt;
    w_blink_nxt    = r_blink;
    w_val_nxt      = 1'b0;
    w_set_mode_nxt = 2'd0;
    w_editing      = (r_state == S_SET_HOUR) || (r_state == S_SET_MIN);
    w_to_hit       = w_ms_tick && (r_to_cnt == TW'(TO_MS - 1));

    // Inactivity timer and blink phase only run while editing
    if (w_editing) begin
      if (w_mode_p || w_inc_p) begin
        w_to_nxt = '0;
      end else if (w_ms_tick) begin
        w_to_nxt = r_to_cnt + TW'(1);
      end
      if (w_ms_tick) begin
        if (r_bl_cnt == BW'(BLINK_MS - 1)) begin
          w_bl_nxt    = '0;
          w_blink_nxt = ~r_blink;
        end else begin
          w_bl_nxt = r_bl_cnt + BW'(1);
        end
      end
    end

    case (r_state)
      S_IDLE: begin
        if (w_mode_p) begin
          w_hour_nxt  = cur_hour_i;
          w_min_nxt   = cur_min_i;
          w_state_nxt = S_SET_HOUR;
        end
      end
      S_SET_HOUR: begin
        if (w_mode_p) begin
          w_state_nxt = S_SET_MIN;
        end else if (w_inc_p) begin
          w_hour_nxt = (r_hour == 5'd23) ? 5'd0 : r_hour + 5'd1;
        end else if (w_to_hit) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SET_MIN: begin
        if (w_mode_p) begin
          w_state_nxt = S_APPLY;
        end else if (w_inc_p) begin
          w_min_nxt = (r_min == 6'd59) ? 6'd0 : r_min + 6'd1;
        end else if (w_to_hit) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Outputs are registered from the next state so they track the FSM exactly
    case (w_state_nxt)
      S_SET_HOUR: w_set_mode_nxt = 2'd1;
      S_SET_MIN:  w_set_mode_nxt = 2'd2;
      default:    w_set_mode_nxt = 2'd0;
    endcase
    w_val_nxt = (w_state_nxt == S_APPLY);

    if ((w_state_nxt == S_IDLE) || (w_state_nxt == S_APPLY)) begin
      w_to_nxt    = '0;
      w_bl_nxt    = '0;
      w_blink_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_hour     <= '0;
      r_min      <= '0;
      r_val      <= 1'b0;
      r_set_mode <= '0;
      r_blink    <= 1'b0;
      r_to_cnt   <= '0;
      r_bl_cnt   <= '0;
    end else begin
      r_hour     <= w_hour_nxt;
      r_min      <= w_min_nxt;
      r_val      <= w_val_nxt;
      r_set_mode <= w_set_mode_nxt;
      r_blink    <= w_blink_nxt;
      r_to_cnt   <= w_to_nxt;
      r_bl_cnt   <= w_bl_nxt;
    end
  end

  assign user_hour_o     = r_hour;
  assign user_min_o      = r_min;
  assign user_time_val_o = r_val;
  assign set_mode_o      = r_set_mode;
  assign blink_o         = r_blink;

endmodule

// File: tb/tb_watches_time_set.sv
// Directed bench for watches_time_set with 50-clock ms ticks.
module tb_watches_time_set;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mode_btn = 1'b0;
  logic       inc_btn = 1'b0;
  logic [4:0] cur_hour = '0;
  logic [5:0] cur_min = '0;
  logic [4:0] user_hour_o;
  logic [5:0] user_min_o;
  logic       user_time_val_o;
  logic [1:0] set_mode_o;
  logic       blink_o;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_strobe = 0;

  localparam int HOLD = 1100;

  watches_time_set #(
    .CLK_FREQ    (50),
    .SIM         (1),
    .DEBOUNCE_MS (20),
    .TIMEOUT_S   (1)
  ) dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .mode_btn_i      (mode_btn),
    .inc_btn_i       (inc_btn),
    .cur_hour_i      (cur_hour),
    .cur_min_i       (cur_min),
    .user_hour_o     (user_hour_o),
    .user_min_o      (user_min_o),
    .user_time_val_o (user_time_val_o),
    .set_mode_o      (set_mode_o),
    .blink_o         (blink_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (user_time_val_o === 1'b1) n_strobe <= n_strobe + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_sm(input logic [1:0] exp, input string tag);
    int k;
    k = 0;
    while (set_mode_o !== exp && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 32'(set_mode_o), 32'(exp));
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic press(input bit m, input bit i);
    if (m) mode_btn = 1'b1;
    if (i) inc_btn = 1'b1;
    idle(HOLD);
    if (m) mode_btn = 1'b0;
    if (i) inc_btn = 1'b0;
    idle(HOLD);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_hour"}, 32'(user_hour_o), 0);
    chk({tag, "_min"}, 32'(user_min_o), 0);
    chk({tag, "_val"}, 32'(user_time_val_o), 0);
    chk({tag, "_mode"}, 32'(set_mode_o), 0);
    chk({tag, "_blink"}, 32'(blink_o), 0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp_hours [3];
    int k;
    int t_entry;
    int t_inc;
    exp_hours[0] = 23;
    exp_hours[1] = 0;
    exp_hours[2] = 1;

    // Reset state
    idle(5);
    chk_all_zero("reset");
    rst_n = 1'b1;
    idle(100);

    // Full set sequence from 22:58
    cur_hour = 5'd22;
    cur_min  = 6'd58;
    press(1, 0);
    chk("seq_mode1", 32'(set_mode_o), 1);
    chk("seq_load_hour", 32'(user_hour_o), 22);
    chk("seq_load_min", 32'(user_min_o), 58);
    for (int n = 0; n < 3; n++) begin
      press(0, 1);
      chk("seq_inc_hour", 32'(user_hour_o), 32'(exp_hours[n]));
    end
    press(1, 0);
    chk("seq_mode2", 32'(set_mode_o), 2);
    chk("seq_hour_kept", 32'(user_hour_o), 1);
    press(0, 1);
    chk("seq_min59", 32'(user_min_o), 59);
    press(0, 1);
    chk("seq_min_wrap", 32'(user_min_o), 0);
    chk("seq_hour_nocarry", 32'(user_hour_o), 1);
    mode_btn = 1'b1;
    wait_sm(2'd0, "seq_mode0");
    chk("apply_strobe", 32'(user_time_val_o), 1);
    chk("apply_hour", 32'(user_hour_o), 1);
    chk("apply_min", 32'(user_min_o), 0);
    @(negedge clk);
    chk("apply_strobe_end", 32'(user_time_val_o), 0);
    chk("apply_hour_hold", 32'(user_hour_o), 1);
    idle(HOLD);
    mode_btn = 1'b0;
    idle(HOLD);
    chk("apply_single_strobe", 32'(n_strobe), 1);

    // Debounce: short glitch ignored, long press accepted, bounce gives one press
    cur_hour = 5'd5;
    cur_min  = 6'd30;
    chk("idle_hour_hold", 32'(user_hour_o), 1);
    mode_btn = 1'b1;
    idle(500);
    mode_btn = 1'b0;
    idle(HOLD);
    chk("glitch10_mode", 32'(set_mode_o), 0);
    chk("glitch10_hour", 32'(user_hour_o), 1);
    mode_btn = 1'b1;
    idle(1250);
    chk("press25_mode", 32'(set_mode_o), 1);
    chk("press25_hour", 32'(user_hour_o), 5);
    mode_btn = 1'b0;
    idle(HOLD);
    mode_btn = 1'b1;
    idle(250);
    mode_btn = 1'b0;
    idle(250);
    mode_btn = 1'b1;
    idle(250 + HOLD);
    mode_btn = 1'b0;
    idle(HOLD);
    chk("bounce_one_press", 32'(set_mode_o), 2);

    // Reset mid-edit with inc held through release
    inc_btn = 1'b1;
    idle(100);
    rst_n = 1'b0;
    idle(1);
    chk_all_zero("rst_async");
    idle(10);
    rst_n = 1'b1;
    idle(HOLD);
    chk_all_zero("rst_release");
    chk("rst_no_strobe", 32'(n_strobe), 1);

    mode_btn = 1'b1;
    wait_sm(2'd1, "rst_enter_hour");
    t_entry = cyc;
    idle(HOLD);
    mode_btn = 1'b0;
    idle(HOLD);
    chk("held_inc_hour", 32'(user_hour_o), 5);
    inc_btn = 1'b0;
    idle(1300);
    chk("released_inc_hour", 32'(user_hour_o), 5);
    press(0, 1);
    chk("repress_inc_hour", 32'(user_hour_o), 6);

    // Simultaneous mode and inc: mode wins
    press(1, 1);
    chk("simul_mode", 32'(set_mode_o), 2);
    chk("simul_hour", 32'(user_hour_o), 6);
    chk("simul_min", 32'(user_min_o), 30);

    // One minute edit, then inactivity timeout
    inc_btn = 1'b1;
    k = 0;
    while (user_min_o !== 6'd31 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("to_edit_min", 32'(user_min_o), 31);
    t_inc = cyc;
    idle(HOLD);
    inc_btn = 1'b0;
    idle(HOLD);

    // Blink phase relative to SET_HOUR entry
    wait_cyc(t_entry + 24900);
    chk("blink_pre500", 32'(blink_o), 0);
    wait_cyc(t_entry + 25100);
    chk("blink_post500", 32'(blink_o), 1);
    wait_cyc(t_entry + 49900);
    chk("blink_pre1000", 32'(blink_o), 1);
    wait_cyc(t_entry + 50100);
    chk("blink_post1000", 32'(blink_o), 0);
    chk("blink_still_min", 32'(set_mode_o), 2);

    wait_cyc(t_inc + 49900);
    chk("to_pre_mode", 32'(set_mode_o), 2);
    wait_cyc(t_inc + 50100);
    chk("to_post_mode", 32'(set_mode_o), 0);
    chk("to_min_kept", 32'(user_min_o), 31);
    chk("to_hour_kept", 32'(user_hour_o), 6);
    chk("to_blink_idle", 32'(blink_o), 0);
    chk("to_no_strobe", 32'(n_strobe), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/watches_time_set.md
# watches_time_set

User time-entry stage of the watches subsystem, directly upstream of the seconds counter. It debounces two raw push-buttons, runs a hour/minute setting state machine, and produces the user hour/minute values plus the one-cycle `user_time_val_o` strobe that zeroes the seconds counter and loads the minute/hour counters. The block also drives the set-mode and blink indications for the display.

## Interface
- `CLK_FREQ`, 50: clock frequency in MHz.
- `SIM`, 0: when 1, one ms tick = `CLK_FREQ` clocks; when 0, one ms tick = `CLK_FREQ*1000` clocks.
- `DEBOUNCE_MS`, 20: ms ticks a synchronized button level must be stable before it is accepted.
- `TIMEOUT_S`, 10: seconds without a press in a set state before leaving without applying.

Ports:
- `clk_i` in 1: system clock.
- `rst_n_i` in 1: asynchronous, active-low reset.
- `mode_btn_i` in 1: raw mode button, active high, asynchronous to `clk_i`.
- `inc_btn_i` in 1: raw increment button, active high, asynchronous to `clk_i`.
- `cur_hour_i` in 5: current hour, 0..23.
- `cur_min_i` in 6: current minute, 0..59.
- `user_hour_o` out 5: hour being edited or applied.
- `user_min_o` out 6: minute being edited or applied.
- `user_time_val_o` out 1: one-cycle apply strobe.
- `set_mode_o` out 2: 0 = idle, 1 = editing hour, 2 = editing minute.
- `blink_o` out 1: display blink phase.

## Operation
- **Tick generator:** free-running prescaler. It emits `ms_tick` for one cycle every N clocks, where N = `CLK_FREQ` (SIM) or `CLK_FREQ*1000`, and wraps to 0 after N-1.
- **Button conditioning:** each button goes through a 2-FF synchronizer.
  - Debounce counter per button, counting ms ticks while the synchronized level differs from the debounced level. It resets to 0 whenever the levels match.
  - When the count reaches `DEBOUNCE_MS`, the debounced level takes the synchronized level.
  - Press = rising edge of the debounced level: a one-cycle pulse (`mode_p`, `inc_p`). Releases produce no pulse.
- **FSM states:** IDLE, SET_HOUR, SET_MIN, APPLY.
- **IDLE:**
  - `mode_p` loads `user_hour_o`←`cur_hour_i` and `user_min_o`←`cur_min_i`, then goes to SET_HOUR.
  - `inc_p` is ignored.
- **SET_HOUR:**
  - `inc_p`: hour = (hour==23) ? 0 : hour+1.
  - `mode_p` goes to SET_MIN.
- **SET_MIN:**
  - `inc_p`: min = (min==59) ? 0 : min+1.
  - `mode_p` goes to APPLY.
- **APPLY:** `user_time_val_o`=1 for exactly this cycle, then unconditionally IDLE. Presses arriving in APPLY are dropped.
- **Timeout:** in SET_HOUR/SET_MIN, a counter of ms ticks is cleared on every `mode_p` or `inc_p`.
  - On reaching `TIMEOUT_S*1000`, go to IDLE with no strobe.
  - `user_hour_o`/`user_min_o` keep their edited values.
- **Outputs:**
  - `set_mode_o` reflects the state: APPLY and IDLE report 0.
  - `blink_o` toggles every 500 ms ticks in the set states. It is forced to 0, and its counter cleared, in IDLE/APPLY and on entry to SET_HOUR.
- `user_hour_o`/`user_min_o` change only on load or increment and hold otherwise.

## Timing
- **Reset:** all outputs 0, FSM IDLE, all counters, synchronizers and debounced levels 0.
- **Reset mid-edit:** returns to IDLE immediately and issues no strobe.
- **Press latency:** raw edge to `*_p`:
  - 2 sync cycles;
  - plus the `DEBOUNCE_MS`-th ms tick after the synchronized change;
  - plus 1 cycle for edge detection.
- **State update:** the state change/load/increment is registered on the cycle `*_p` is high and is visible the next cycle.
- **Strobe:** `user_time_val_o` is asserted the cycle after the SET_MIN `mode_p`. `user_hour_o`/`user_min_o` are stable during and after the strobe.
- **Simultaneous events:**
  - `mode_p` and `inc_p` in the same cycle: mode wins, inc is discarded.
  - Press and timeout expiry in the same cycle: press wins and the timeout counter clears.
- **Wrap-around:** hour 23→0, minute 59→0, no carry between fields.
- **Glitches:** a glitch shorter than `DEBOUNCE_MS` ms produces no pulse.

## Test plan
All scenarios use `SIM`=1, `CLK_FREQ`=50 (ms tick = 50 clocks), `DEBOUNCE_MS`=20 and `TIMEOUT_S`=1.
- **Full set sequence:** `cur_hour_i`=22, `cur_min_i`=58; press mode, inc×3, mode, inc×2, mode → `user_hour_o`=1, `user_min_o`=0, single-cycle `user_time_val_o`, `set_mode_o` sequence 1,2,0.
- **Debounce:** 10 ms mode pulse → no state change; 25 ms pulse → SET_HOUR. Bouncing edges (5 ms toggles for 15 ms, then stable) → exactly one `mode_p`.
- **Timeout:** enter SET_MIN, edit once, idle 1000 ms ticks → IDLE, `user_time_val_o` never asserted, `user_min_o` keeps the edited value.
- **Simultaneous presses:** mode and inc debounced in the same cycle in SET_HOUR → SET_MIN, hour unchanged.
- **Blink:** in SET_HOUR, `blink_o` toggles at ms ticks 500 and 1000. It reads 0 in IDLE.
- **Reset:** `rst_n_i` low in SET_MIN, released → all outputs 0, IDLE. Held inc during reset release produces no pulse until released and pressed again.
